// File: rtl/alu_pkg.sv
// Shared types for the sequential ALU/MDU: function codes, controller states
// and decode helpers.
package alu_pkg;

  typedef enum logic [3:0] {
    ADD   = 4'b0000,
    ADDU  = 4'b0001,
    SUB   = 4'b0010,
    SUBU  = 4'b0011,
    AND   = 4'b0100,
    OR    = 4'b0101,
    XOR   = 4'b0110,
    NOR   = 4'b0111,
    UND8  = 4'b1000,
    UND9  = 4'b1001,
    SLT   = 4'b1010,
    SLTU  = 4'b1011,
    MULT  = 4'b1100,
    MULTU = 4'b1101,
    DIV   = 4'b1110,
    DIVU  = 4'b1111
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    FIX
  } state_t;

  function automatic logic is_multicycle(alu_op_t op);
    return (op[3:2] == 2'b11);
  endfunction

endpackage

// File: rtl/alu_mdu_seq_if.sv
// Request/result bundle between the register-read stage and alu_mdu_seq.
interface alu_mdu_seq_if #(parameter int N = 32);
  import alu_pkg::*;

  logic           in_valid;
  logic           in_ready;
  alu_op_t        F;
  logic [N-1:0]   A;
  logic [N-1:0]   B;
  logic           out_valid;
  logic [N-1:0]   Y;
  logic [N-1:0]   HI;
  logic [N-1:0]   LO;
  logic           Cout;
  logic           OV;
  logic           Zero;
  logic           DZ;

  modport master (
    output in_valid, F, A, B,
    input  in_ready, out_valid, Y, HI, LO, Cout, OV, Zero, DZ
  );

  modport slave (
    input  in_valid, F, A, B,
    output in_ready, out_valid, Y, HI, LO, Cout, OV, Zero, DZ
  );

endinterface

// File: rtl/mdu_iter.sv
// Radix-2 iterative multiply/divide datapath: shift-add multiply, restoring
// divide, operands held as magnitudes with the sign fixed up at the end.
module mdu_iter
  import alu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         step,
  input  alu_op_t      op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] res_hi,
  output logic [N-1:0] res_lo,
  output logic         res_div,
  output logic         res_dz
);

  logic [N-1:0]   acc, sh, opnd, a_raw;
  logic           div_r, neg_q, neg_r, dz_r;
  logic           sgn, a_neg, b_neg;
  logic [N-1:0]   a_mag, b_mag;
  logic [N:0]     sum, shifted, diff;
  logic [N-1:0]   acc_n, sh_n;
  logic [2*N-1:0] prod, prod_s;

  // Magnitudes fit in N bits unsigned: |MIN| = 2^(N-1).
  always_comb begin
    sgn   = !op[0];
    a_neg = sgn & a[N-1];
    b_neg = sgn & b[N-1];
    a_mag = a_neg ? -a : a;
    b_mag = b_neg ? -b : b;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc   <= '0;
      sh    <= '0;
      opnd  <= '0;
      a_raw <= '0;
      div_r <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dz_r  <= 1'b0;
    end else if (load) begin
      acc   <= '0;
      sh    <= op[1] ? a_mag : b_mag;
      opnd  <= op[1] ? b_mag : a_mag;
      a_raw <= a;
      div_r <= op[1];
      neg_q <= a_neg ^ b_neg;
      neg_r <= a_neg;
      dz_r  <= op[1] && (b == '0);
    end else if (step) begin
      acc <= acc_n;
      sh  <= sh_n;
    end
  end

  always_comb begin
    sum     = {1'b0, acc} + {1'b0, (sh[0] ? opnd : '0)};
    shifted = {acc, sh[N-1]};
    diff    = shifted - {1'b0, opnd};
    if (div_r) begin
      if (!diff[N]) begin
        acc_n = diff[N-1:0];
        sh_n  = {sh[N-2:0], 1'b1};
      end else begin
        acc_n = shifted[N-1:0];
        sh_n  = {sh[N-2:0], 1'b0};
      end
    end else begin
      acc_n = sum[N:1];
      sh_n  = {sum[0], sh[N-1:1]};
    end
  end

  // The last radix-2 step is consumed combinationally in FIX, so only N-1
  // steps are registered during BUSY.
  always_comb begin
    prod   = {acc_n, sh_n};
    prod_s = neg_q ? -prod : prod;
    if (dz_r) begin
      res_hi = a_raw;
      res_lo = '1;
    end else if (div_r) begin
      res_lo = neg_q ? -sh_n : sh_n;
      res_hi = neg_r ? -acc_n : acc_n;
    end else begin
      res_hi = prod_s[2*N-1:N];
      res_lo = prod_s[N-1:0];
    end
    res_div = div_r;
    res_dz  = dz_r;
  end

endmodule

// File: rtl/alu_mdu_seq.sv
// Registered, handshaked integer ALU with iterative multiply/divide unit.
module alu_mdu_seq
  import alu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         reset,
  alu_mdu_seq_if.slave bus
);

  localparam int CW = $clog2(N) + 1;

  state_t         state, state_n;
  logic [CW-1:0]  cnt;
  alu_op_t        op_in;
  logic           accept, mc_accept, dz_start;
  logic           load, step, fix;
  logic [N:0]     add_u, sub_u;
  logic [N-1:0]   alu_y;
  logic           alu_cout, alu_ov;
  logic [N-1:0]   res_hi, res_lo;
  logic           res_div, res_dz;

  assign op_in       = bus.F;
  assign bus.in_ready = (state == IDLE);
  assign accept      = bus.in_valid && (state == IDLE);
  assign mc_accept   = accept && is_multicycle(op_in);
  assign dz_start    = mc_accept && op_in[1] && (bus.B == '0);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (reset)     cnt <= '0;
    else if (load) cnt <= CW'(N);
    else if (step) cnt <= cnt - CW'(1);
  end

  // BUSY covers cnt = N..2; the final step happens in FIX with cnt == 1.
  always_comb begin
    state_n = state;
    load    = 1'b0;
    step    = 1'b0;
    fix     = 1'b0;
    case (state)
      IDLE: begin
        if (mc_accept) begin
          load    = 1'b1;
          state_n = dz_start ? FIX : BUSY;
        end
      end
      BUSY: begin
        step = 1'b1;
        if (cnt == CW'(2)) state_n = FIX;
      end
      FIX: begin
        fix     = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    add_u    = {1'b0, bus.A} + {1'b0, bus.B};
    sub_u    = {1'b0, bus.A} - {1'b0, bus.B};
    alu_y    = '0;
    alu_cout = 1'b0;
    alu_ov   = 1'b0;
    case (op_in)
      ADD: begin
        alu_y  = add_u[N-1:0];
        alu_ov = (bus.A[N-1] == bus.B[N-1]) && (add_u[N-1] != bus.A[N-1]);
      end
      ADDU: begin
        alu_y    = add_u[N-1:0];
        alu_cout = add_u[N];
      end
      SUB: begin
        alu_y  = sub_u[N-1:0];
        alu_ov = (bus.A[N-1] != bus.B[N-1]) && (sub_u[N-1] != bus.A[N-1]);
      end
      SUBU: begin
        alu_y    = sub_u[N-1:0];
        alu_cout = sub_u[N];
      end
      AND:  alu_y = bus.A & bus.B;
      OR:   alu_y = bus.A | bus.B;
      XOR:  alu_y = bus.A ^ bus.B;
      NOR:  alu_y = ~(bus.A | bus.B);
      SLT:  alu_y = {{(N-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
      SLTU: alu_y = {{(N-1){1'b0}}, (bus.A < bus.B)};
      default: alu_y = '0;
    endcase
  end

  mdu_iter #(.N(N)) u_mdu (
    .clk     (clk),
    .reset   (reset),
    .load    (load),
    .step    (step),
    .op      (op_in),
    .a       (bus.A),
    .b       (bus.B),
    .res_hi  (res_hi),
    .res_lo  (res_lo),
    .res_div (res_div),
    .res_dz  (res_dz)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.out_valid <= 1'b0;
      bus.Y         <= '0;
      bus.HI        <= '0;
      bus.LO        <= '0;
      bus.Cout      <= 1'b0;
      bus.OV        <= 1'b0;
      bus.Zero      <= 1'b1;
      bus.DZ        <= 1'b0;
    end else begin
      bus.out_valid <= 1'b0;
      if (accept && !is_multicycle(op_in)) begin
        bus.Y         <= alu_y;
        bus.Cout      <= alu_cout;
        bus.OV        <= alu_ov;
        bus.Zero      <= (alu_y == '0);
        bus.out_valid <= 1'b1;
      end
      if (fix) begin
        bus.HI        <= res_hi;
        bus.LO        <= res_lo;
        bus.Y         <= res_lo;
        bus.Zero      <= (res_lo == '0);
        bus.Cout      <= 1'b0;
        bus.OV        <= 1'b0;
        if (res_div) bus.DZ <= res_dz;
        bus.out_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_mdu_seq.sv
// Directed plus randomized bench for alu_mdu_seq against a plain-arithmetic model.
module tb_alu_mdu_seq;
  import alu_pkg::*;

  localparam int N = 32;

  logic clk = 1'b0;
  logic reset;

  alu_mdu_seq_if #(.N(N)) bus ();

  alu_mdu_seq #(.N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [N-1:0] m_hi, m_lo;
  logic         m_dz;
  logic [N-1:0] e_y;
  logic         e_cout, e_ov, e_zero;
  int           e_lat;
  bit           e_multi;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model(input alu_op_t op, input logic [N-1:0] a, input logic [N-1:0] b);
    longint     sa, sb, r64;
    logic [63:0] u;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    e_y = '0; e_cout = 1'b0; e_ov = 1'b0; e_lat = 1;
    e_multi = (op inside {MULT, MULTU, DIV, DIVU});
    case (op)
      ADD:  begin r64 = sa + sb; e_y = r64[31:0];
                  e_ov = (r64 > 64'sd2147483647) || (r64 < -64'sd2147483648); end
      ADDU: begin u = {32'd0, a} + {32'd0, b}; e_y = u[31:0]; e_cout = u[32]; end
      SUB:  begin r64 = sa - sb; e_y = r64[31:0];
                  e_ov = (r64 > 64'sd2147483647) || (r64 < -64'sd2147483648); end
      SUBU: begin e_y = a - b; e_cout = (a < b); end
      AND:  e_y = a & b;
      OR:   e_y = a | b;
      XOR:  e_y = a ^ b;
      NOR:  e_y = ~(a | b);
      SLT:  e_y = (sa < sb) ? 32'd1 : 32'd0;
      SLTU: e_y = (a < b) ? 32'd1 : 32'd0;
      MULT: begin r64 = sa * sb; {m_hi, m_lo} = r64; end
      MULTU: begin u = {32'd0, a} * {32'd0, b}; {m_hi, m_lo} = u; end
      DIV: begin
        if (b == 0) begin m_lo = '1; m_hi = a; m_dz = 1'b1; e_lat = 2; end
        else begin
          r64 = sa / sb; m_lo = r64[31:0];
          r64 = sa % sb; m_hi = r64[31:0];
          m_dz = 1'b0;
        end
      end
      DIVU: begin
        if (b == 0) begin m_lo = '1; m_hi = a; m_dz = 1'b1; e_lat = 2; end
        else begin m_lo = a / b; m_hi = a % b; m_dz = 1'b0; end
      end
      default: e_y = '0;
    endcase
    if (e_multi) begin
      if (e_lat != 2) e_lat = N + 1;
      e_y = m_lo;
    end
    e_zero = (e_y == 0);
  endtask

  // Called at a negedge with the DUT idle; returns at the out_valid negedge.
  task automatic issue(input alu_op_t op, input logic [N-1:0] a, input logic [N-1:0] b,
                       input bit hold, input alu_op_t nop,
                       input logic [N-1:0] na, input logic [N-1:0] nb);
    bit seen;
    int lat_seen;
    bus.in_valid = 1'b1; bus.F = op; bus.A = a; bus.B = b;
    check("in_ready_idle", bus.in_ready, 1);
    @(posedge clk);
    model(op, a, b);
    seen = 0; lat_seen = 0;
    for (int lat = 1; lat <= 40; lat++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) begin
        seen = 1; lat_seen = lat;
        break;
      end
      check("in_ready_busy", bus.in_ready, e_multi ? 0 : 1);
      if (hold && lat == 1) begin
        bus.F = nop; bus.A = na; bus.B = nb;
      end else if (!hold) begin
        bus.in_valid = 1'b0;
        bus.F = alu_op_t'(4'($urandom_range(0, 15)));
        bus.A = $urandom; bus.B = $urandom;
      end
    end
    if (!seen) check("out_valid_timeout", bus.out_valid, 1);
    else       check("latency", lat_seen, e_lat);
    check("Y", bus.Y, e_y);
    check("HI", bus.HI, m_hi);
    check("LO", bus.LO, m_lo);
    check("Cout", bus.Cout, e_cout);
    check("OV", bus.OV, e_ov);
    check("Zero", bus.Zero, e_zero);
    check("DZ", bus.DZ, m_dz);
    if (!hold) bus.in_valid = 1'b0;
  endtask

  task automatic run(input alu_op_t op, input logic [N-1:0] a, input logic [N-1:0] b);
    issue(op, a, b, 1'b0, ADD, '0, '0);
  endtask

  task automatic idle_check();
    @(negedge clk);
    check("out_valid_pulse", bus.out_valid, 0);
    check("LO_hold", bus.LO, m_lo);
    check("Y_hold", bus.Y, e_y);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] ra, rb;
    logic [N-1:0] specials [6];
    int pulses;
    alu_op_t rop;
    specials[0] = 32'h8000_0000; specials[1] = 32'hFFFF_FFFF; specials[2] = 32'h7FFF_FFFF;
    specials[3] = 32'h0000_0001; specials[4] = 32'h0000_0000; specials[5] = 32'hFFFF_FFFE;

    bus.in_valid = 1'b0; bus.F = ADD; bus.A = '0; bus.B = '0;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_Y", bus.Y, 0);
    check("rst_HI", bus.HI, 0);
    check("rst_LO", bus.LO, 0);
    check("rst_flags", {bus.Cout, bus.OV, bus.DZ, bus.Zero}, 4'b0001);
    reset = 1'b0;
    m_hi = '0; m_lo = '0; m_dz = 1'b0; e_y = '0;

    run(ADD,  32'h7FFF_FFFF, 32'h1);
    run(ADDU, 32'hFFFF_FFFF, 32'h1);
    idle_check();
    run(SUB,  32'h8000_0000, 32'h1);
    run(SUBU, 32'h1, 32'h2);
    run(SLT,  32'hFFFF_FFFF, 32'h1);
    run(SLTU, 32'hFFFF_FFFF, 32'h1);
    run(NOR,  32'h0F0F_0000, 32'h0000_F0F0);
    run(MULT,  32'hFFFF_FFFF, 32'd5);
    run(MULTU, 32'hFFFF_FFFF, 32'd5);
    run(DIV,  32'hFFFF_FFF9, 32'd2);
    run(DIVU, 32'd7, 32'd2);
    run(DIV,  32'h8000_0000, 32'hFFFF_FFFF);
    run(DIVU, 32'd9, 32'd0);
    idle_check();
    run(DIVU, 32'd9, 32'd3);
    run(UND8, 32'h1234_5678, 32'h1);
    run(UND9, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    // in_valid held through a DIV while the inputs already show the next op
    issue(DIV, 32'hFFFF_FF9C, 32'd7, 1'b1, MULTU, 32'hDEAD_BEEF, 32'h1234_5678);
    run(MULTU, 32'hDEAD_BEEF, 32'h1234_5678);
    idle_check();

    for (int i = 0; i < 60; i++) begin
      rop = alu_op_t'(4'($urandom_range(0, 15)));
      ra = ($urandom_range(0, 5) == 0) ? specials[$urandom_range(0, 5)] : 32'($urandom);
      case ($urandom_range(0, 7))
        0:       rb = '0;
        1:       rb = specials[$urandom_range(0, 5)];
        2:       rb = 32'($urandom_range(1, 15));
        default: rb = 32'($urandom);
      endcase
      run(rop, ra, rb);
      if (i % 5 == 4) idle_check();
    end

    // Reset during a MULT: discarded, no out_valid afterwards
    run(ADD, 32'd1, 32'd2);
    bus.in_valid = 1'b1; bus.F = MULT; bus.A = 32'h1234_5678; bus.B = 32'h9ABC_DEF0;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_in_ready", bus.in_ready, 1);
    check("midrst_Y", bus.Y, 0);
    check("midrst_HI", bus.HI, 0);
    check("midrst_LO", bus.LO, 0);
    check("midrst_flags", {bus.Cout, bus.OV, bus.DZ, bus.Zero}, 4'b0001);
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) pulses++;
    end
    check("midrst_no_pulse", pulses, 0);
    m_hi = '0; m_lo = '0; m_dz = 1'b0;
    run(MULTU, 32'd3, 32'd4);
    run(DIV, 32'd100, 32'hFFFF_FFFD);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
